// File: rtl/reg_load_sequencer_pkg.sv
// Shared types and elaboration-time helpers for the register-load sequencer.
// FSM state encoding plus the phase-length clamp used to size and load the phase counter.
package reg_load_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // The strobe phase can never be shorter than one cycle or nothing would be captured.
  function automatic int clamp_min1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reg_load_sequencer_if.sv
// Request handshake plus register-bank drive lines between requester, sequencer and registers.
// master = requester side, slave = sequencer side.
interface reg_load_sequencer_if #(
  parameter int DATA_W = 4,
  parameter int NREGS  = 4
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic              req;
  logic              ready;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] data;
  logic [NREGS-1:0]  load_n;
  logic              done;
  logic              err;

  modport master (output req, addr, din, input ready, data, load_n, done, err);
  modport slave  (input req, addr, din, output ready, data, load_n, done, err);
endinterface

// File: rtl/reg_load_sequencer_phase_counter.sv
// Loadable down-counter timing one sequencer phase; o_last flags the final cycle of the phase.
// Reload takes priority; the count parks at 1 until the next reload.
module reg_load_sequencer_phase_counter #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_last
);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && !o_last && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_last = (r_cnt == CW'(1));
endmodule

// File: rtl/reg_load_sequencer.sv
// Drives one nibble write into an active-low-load register bank: setup, strobe, hold phases.
// Accept-to-ready = SETUP_CYC+STROBE_CYC+HOLD_CYC cycles; ready is low for the whole transaction.
module reg_load_sequencer
  import reg_load_sequencer_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int NREGS      = 4,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 1,
  parameter int HOLD_CYC   = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  reg_load_sequencer_if.slave bus
);
  localparam int AW   = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int STB  = clamp_min1(STROBE_CYC);
  localparam int MAXC = max3(SETUP_CYC, STB, HOLD_CYC);
  localparam int CW   = $clog2(MAXC + 1);

  state_e            r_state, w_state_nxt;
  logic [AW-1:0]     r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic [NREGS-1:0]  r_load_n, w_load_n_nxt;
  logic              w_cnt_load;
  logic [CW-1:0]     w_cnt_val;
  logic              w_cnt_last;

  reg_load_sequencer_phase_counter #(.CW(CW)) u_phase_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_en       (r_state != ST_IDLE),
    .o_last     (w_cnt_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_ready_nxt = r_ready;
    w_done_nxt  = 1'b0;
    w_cnt_val   = '0;
    unique case (r_state)
      ST_IDLE: begin
        w_ready_nxt = 1'b1;
        if (r_ready && bus.req) begin
          w_ready_nxt = 1'b0;
          w_addr_nxt  = bus.addr;
          w_data_nxt  = bus.din;
          w_state_nxt = (SETUP_CYC > 0) ? ST_SETUP : ST_STROBE;
        end
      end
      ST_SETUP: begin
        if (w_cnt_last) w_state_nxt = ST_STROBE;
      end
      ST_STROBE: begin
        if (w_cnt_last) begin
          if (HOLD_CYC > 0) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_IDLE;
            w_ready_nxt = 1'b1;
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (w_cnt_last) begin
          w_state_nxt = ST_IDLE;
          w_ready_nxt = 1'b1;
          w_done_nxt  = 1'b1;
        end
      end
    endcase

    w_err_nxt  = w_done_nxt && (int'(r_addr) >= NREGS);
    w_cnt_load = (w_state_nxt != r_state) && (w_state_nxt != ST_IDLE);
    case (w_state_nxt)
      ST_SETUP:  w_cnt_val = CW'(SETUP_CYC);
      ST_STROBE: w_cnt_val = CW'(STB);
      ST_HOLD:   w_cnt_val = CW'(HOLD_CYC);
      default:   w_cnt_val = '0;
    endcase

    // Decode from the next state so load_n comes straight out of a flop; out-of-range addr matches no line.
    w_load_n_nxt = '1;
    for (int i = 0; i < NREGS; i++) begin
      if ((w_state_nxt == ST_STROBE) && (w_addr_nxt == AW'(i))) w_load_n_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_data   <= '0;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_load_n <= '1;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_ready  <= w_ready_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_load_n <= w_load_n_nxt;
    end
  end

  assign bus.ready  = r_ready;
  assign bus.data   = r_data;
  assign bus.load_n = r_load_n;
  assign bus.done   = r_done;
  assign bus.err    = r_err;
endmodule

// File: tb/tb_reg_load_sequencer.sv
// Bench: three sequencer configurations against a transaction-timeline reference model.
module tb_reg_load_sequencer;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  // per-DUT configuration: 0 = defaults, 1 = no setup/hold with 2-cycle strobe, 2 = three registers
  int S [3] = '{1, 0, 1};
  int ST[3] = '{1, 2, 1};
  int H [3] = '{1, 0, 1};
  int NR[3] = '{4, 4, 3};

  logic       req_v [3];
  logic [1:0] addr_v[3];
  logic [3:0] din_v [3];
  logic [3:0] ld_v  [3];
  logic [3:0] dat_v [3];
  logic       rdy_v [3];
  logic       done_v[3];
  logic       err_v [3];

  reg_load_sequencer_if #(.DATA_W(4), .NREGS(4)) if_a ();
  reg_load_sequencer_if #(.DATA_W(4), .NREGS(4)) if_b ();
  reg_load_sequencer_if #(.DATA_W(4), .NREGS(3)) if_c ();

  reg_load_sequencer #(.DATA_W(4), .NREGS(4), .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1))
    u_a (.clk(clk), .reset_n(rst_n), .bus(if_a));
  reg_load_sequencer #(.DATA_W(4), .NREGS(4), .SETUP_CYC(0), .STROBE_CYC(2), .HOLD_CYC(0))
    u_b (.clk(clk), .reset_n(rst_n), .bus(if_b));
  reg_load_sequencer #(.DATA_W(4), .NREGS(3), .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1))
    u_c (.clk(clk), .reset_n(rst_n), .bus(if_c));

  assign if_a.req = req_v[0];  assign if_a.addr = addr_v[0];  assign if_a.din = din_v[0];
  assign if_b.req = req_v[1];  assign if_b.addr = addr_v[1];  assign if_b.din = din_v[1];
  assign if_c.req = req_v[2];  assign if_c.addr = addr_v[2];  assign if_c.din = din_v[2];

  assign ld_v[0] = if_a.load_n;           assign ld_v[1] = if_b.load_n;
  assign ld_v[2] = {1'b1, if_c.load_n};
  assign dat_v[0] = if_a.data;  assign dat_v[1] = if_b.data;  assign dat_v[2] = if_c.data;
  assign rdy_v[0] = if_a.ready; assign rdy_v[1] = if_b.ready; assign rdy_v[2] = if_c.ready;
  assign done_v[0] = if_a.done; assign done_v[1] = if_b.done; assign done_v[2] = if_c.done;
  assign err_v[0] = if_a.err;   assign err_v[1] = if_b.err;   assign err_v[2] = if_c.err;

  // downstream register bank on DUT 0, captures whenever its load line is low at an edge
  logic [3:0] bank_a[4];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (!if_a.load_n[i]) bank_a[i] <= if_a.data;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each transaction is a timeline k = edges since accept, done at k = S+ST+H.
  logic       m_busy [3];
  logic       m_ready[3];
  logic       m_done [3];
  logic       m_err  [3];
  int         m_k    [3];
  int         m_addr [3];
  logic [3:0] m_data [3];

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        m_busy[d] <= 1'b0; m_ready[d] <= 1'b0; m_done[d] <= 1'b0; m_err[d] <= 1'b0;
        m_k[d] <= 0; m_addr[d] <= 0; m_data[d] <= 4'h0;
      end else begin
        m_done[d] <= 1'b0;
        m_err[d]  <= 1'b0;
        if (m_busy[d]) begin
          m_k[d] <= m_k[d] + 1;
          if (m_k[d] + 1 == S[d] + ST[d] + H[d]) begin
            m_busy[d]  <= 1'b0;
            m_ready[d] <= 1'b1;
            m_done[d]  <= 1'b1;
            m_err[d]   <= (m_addr[d] >= NR[d]);
          end
        end else if (m_ready[d] && req_v[d]) begin
          m_busy[d]  <= 1'b1;
          m_ready[d] <= 1'b0;
          m_k[d]     <= 0;
          m_addr[d]  <= int'(addr_v[d]);
          m_data[d]  <= din_v[d];
        end else begin
          m_ready[d] <= 1'b1;
        end
      end
    end
  end

  function automatic logic [3:0] exp_ld(input int d);
    logic [3:0] v;
    v = 4'hF;
    if (m_busy[d] && m_k[d] >= S[d] && m_k[d] < S[d] + ST[d] && m_addr[d] < NR[d])
      v[m_addr[d]] = 1'b0;
    return v;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 3; d++) begin
        check($sformatf("dut%0d.load_n", d), 32'(ld_v[d]), 32'(exp_ld(d)));
        check($sformatf("dut%0d.data", d), 32'(dat_v[d]), 32'(m_data[d]));
        check($sformatf("dut%0d.ready", d), 32'(rdy_v[d]), 32'(m_ready[d]));
        check($sformatf("dut%0d.done", d), 32'(done_v[d]), 32'(m_done[d]));
        check($sformatf("dut%0d.err", d), 32'(err_v[d]), 32'(m_err[d]));
        check($sformatf("dut%0d.one_low", d), 32'($countones(~ld_v[d]) <= 1), 32'd1);
      end
    end
  end

  task automatic wait_done(input int d, input int budget);
    int n;
    n = 0;
    while (!done_v[d] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("dut%0d.done_within_budget", d), 32'(done_v[d]), 32'd1);
  endtask

  task automatic drive(input int d, input logic r, input logic [1:0] a, input logic [3:0] v);
    req_v[d] = r; addr_v[d] = a; din_v[d] = v;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 2'd0, 4'h0);
    #2 rst_n = 1'b0;
    #1 cmp_en = 1'b1;

    // reset held for 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.load_n", 32'(if_a.load_n), 32'hF);
    check("rst.data", 32'(if_a.data), 32'h0);
    check("rst.ready", 32'(if_a.ready), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.ready_after_release", 32'(if_a.ready), 32'h1);

    // single write addr=2 din=5
    drive(0, 1'b1, 2'd2, 4'h5);
    @(negedge clk);
    drive(0, 1'b0, 2'd0, 4'h0);
    check("wr.ready_low", 32'(if_a.ready), 32'h0);
    check("wr.data", 32'(if_a.data), 32'h5);
    @(negedge clk);
    check("wr.strobe", 32'(if_a.load_n), 32'hB);
    @(negedge clk);
    check("wr.hold_load_n", 32'(if_a.load_n), 32'hF);
    check("wr.hold_data", 32'(if_a.data), 32'h5);
    @(negedge clk);
    check("wr.done", 32'(if_a.done), 32'h1);
    check("wr.bank2", 32'(bank_a[2]), 32'h5);

    // back-to-back with req held high
    drive(0, 1'b1, 2'd0, 4'hA);
    @(negedge clk);
    drive(0, 1'b1, 2'd3, 4'h2);
    repeat (3) @(negedge clk);
    check("b2b.done1", 32'(if_a.done), 32'h1);
    check("b2b.data1", 32'(if_a.data), 32'hA);
    check("b2b.bank0", 32'(bank_a[0]), 32'hA);
    @(negedge clk);
    check("b2b.second_accept", 32'(if_a.ready), 32'h0);
    check("b2b.data2", 32'(if_a.data), 32'h2);
    drive(0, 1'b0, 2'd0, 4'h0);
    wait_done(0, 10);
    check("b2b.bank3", 32'(bank_a[3]), 32'h2);

    // no setup/hold, 2-cycle strobe
    drive(1, 1'b1, 2'd1, 4'h7);
    @(negedge clk);
    drive(1, 1'b0, 2'd0, 4'h0);
    check("cfgb.strobe1", 32'(if_b.load_n), 32'hD);
    check("cfgb.ready_low", 32'(if_b.ready), 32'h0);
    @(negedge clk);
    check("cfgb.strobe2", 32'(if_b.load_n), 32'hD);
    @(negedge clk);
    check("cfgb.release", 32'(if_b.load_n), 32'hF);
    check("cfgb.ready", 32'(if_b.ready), 32'h1);
    check("cfgb.done", 32'(if_b.done), 32'h1);

    // out-of-range index on the three-register instance
    drive(2, 1'b1, 2'd3, 4'h9);
    @(negedge clk);
    drive(2, 1'b0, 2'd0, 4'h0);
    check("oor.data", 32'(if_c.data), 32'h9);
    @(negedge clk);
    check("oor.no_load", 32'(if_c.load_n), 32'h7);
    repeat (2) @(negedge clk);
    check("oor.done", 32'(if_c.done), 32'h1);
    check("oor.err", 32'(if_c.err), 32'h1);
    check("oor.data_kept", 32'(if_c.data), 32'h9);

    // reset asserted mid-strobe
    drive(0, 1'b1, 2'd1, 4'h3);
    @(negedge clk);
    drive(0, 1'b0, 2'd0, 4'h0);
    @(negedge clk);
    check("abort.strobe", 32'(if_a.load_n), 32'hD);
    #2 rst_n = 1'b0;
    #1;
    check("abort.load_n", 32'(if_a.load_n), 32'hF);
    check("abort.done", 32'(if_a.done), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b1, 2'd1, 4'h6);
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b0, 2'd0, 4'h0);
    wait_done(0, 10);
    check("abort.rewrite_bank1", 32'(bank_a[1]), 32'h6);

    // randomized traffic on all three instances
    repeat (3000) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        drive(d, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom));
    end
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 2'd0, 4'h0);
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
